// File: rtl/serial_frame_rx_if.sv
// Bus bundle between a serial line source/word consumer and serial_frame_rx.
// Handshake: a word transfers on every rising clk edge where out_valid && out_ready.
// out_data is held stable while out_valid=1 and not accepted. out_ready while
// out_valid=0 is ignored.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             d_in;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic             overrun;

    // Line driver and word consumer side
    modport master (
        output d_in, out_ready,
        input  out_data, out_valid, frame_err, overrun
    );

    // Receiver side
    modport slave (
        input  d_in, out_ready,
        output out_data, out_valid, frame_err, overrun
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit (0), WIDTH data bits LSB-first, stop bit (1).
// Good frames go into a one-entry holding register behind a valid/ready handshake.
// A bad stop bit pulses frame_err and parks the FSM in BREAK until the line idles.
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_frame_rx_if.slave    bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP  = 2'd2,
        BREAK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    // Control decoded from the current state
    logic start_det;
    logic shift_en;
    logic load_word;
    logic drop_word;
    logic stop_bad;
    logic hold_free;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!bus.d_in) state_d = DATA;
            DATA:  if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
            STOP:  state_d = bus.d_in ? IDLE : BREAK;
            BREAK: if (bus.d_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode; the holding register is free if empty or being drained now
    always_comb begin
        hold_free = !out_valid_q || bus.out_ready;
        start_det = 1'b0;
        shift_en  = 1'b0;
        load_word = 1'b0;
        drop_word = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: start_det = !bus.d_in;
            DATA: shift_en  = 1'b1;
            STOP: begin
                load_word = bus.d_in && hold_free;
                drop_word = bus.d_in && !hold_free;
                stop_bad  = !bus.d_in;
            end
            default: ;
        endcase
    end

    // Bit counter and shift register: new bits enter at the MSB so the first lands at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            if (start_det) cnt_q <= '0;
            else if (shift_en) cnt_q <= cnt_q + CW'(1);
            if (shift_en) shift_q <= {bus.d_in, shift_q[WIDTH-1:1]};
        end
    end

    // Holding register and status flags; a load on an accept edge keeps out_valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (load_word) begin
                out_data_q  <= shift_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            frame_err_q <= stop_bad;
            if (drop_word) overrun_q <= 1'b1;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx with WIDTH=8: directed scenarios plus a randomized
// frame stream checked against a word-level expected queue.
module tb_serial_frame_rx;
    localparam int W = 8;

    logic clk;
    logic rst;
    logic [1:0] state_dbg;

    serial_frame_rx_if #(.WIDTH(W)) bus ();

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int total;
    int bad;
    int cyc;
    int err_cnt;
    int         vcyc_q[$];
    logic [W-1:0] vdat_q[$];
    logic [W-1:0] exp_q[$];

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs for the next edge, wait for it, then sample #1 later and log.
    task automatic tick(input logic b, input logic r);
        bus.d_in      = b;
        bus.out_ready = r;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid === 1'b1) begin
            vcyc_q.push_back(cyc);
            vdat_q.push_back(bus.out_data);
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop,
                              input logic r_data, input logic r_stop);
        tick(1'b0, r_data);
        for (int k = 0; k < W; k++) tick(word[k], r_data);
        tick(stop, r_stop);
    endtask

    task automatic clear_logs();
        vcyc_q.delete();
        vdat_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.frame_err !== 1'b0 ||
            bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b data=%h err=%b ovr=%b required all 0",
                     bus.out_valid, bus.out_data, bus.frame_err, bus.overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_logs();
        repeat (3) tick(1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
            bad++;
            $display("FAIL single_word: valid=%b data=%h required 1/a5", bus.out_valid, bus.out_data);
        end
        repeat (2) tick(1'b1, 1'b1);
        total++;
        if (vcyc_q.size() != 1) begin
            bad++;
            $display("FAIL single_valid_cycles: got %0d required 1", vcyc_q.size());
        end
        total++;
        if (err_cnt != 0 || bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL single_flags: err_pulses=%0d ovr=%b required 0/0", err_cnt, bus.overrun);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1);
        total++;
        if (vdat_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d valid cycles required 2", vdat_q.size());
        end else begin
            total++;
            if (vdat_q[0] !== 8'h3C || vdat_q[1] !== 8'hC3) begin
                bad++;
                $display("FAIL b2b_data: got %h,%h required 3c,c3", vdat_q[0], vdat_q[1]);
            end
            total++;
            if (vcyc_q[1] - vcyc_q[0] != W + 2) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d required %0d", vcyc_q[1] - vcyc_q[0], W + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.overrun !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: valid=%b data=%h ovr=%b required 1/11/1",
                     bus.out_valid, bus.out_data, bus.overrun);
        end
        tick(1'b1, 1'b1);
        total++;
        if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain: valid=%b ovr=%b required 0/1", bus.out_valid, bus.overrun);
        end
        tick(1'b1, 1'b0);
    endtask

    task automatic test_accept_and_load();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b0, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h66 || bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL accept_load: valid=%b data=%h ovr=%b required 1/66/0",
                     bus.out_valid, bus.out_data, bus.overrun);
        end
        tick(1'b1, 1'b1);
    endtask

    task automatic test_bad_stop();
        clear_logs();
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        total++;
        if (bus.frame_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_stop_pulse: err=%b valid=%b required 1/0", bus.frame_err, bus.out_valid);
        end
        repeat (5) tick(1'b0, 1'b1);
        total++;
        if (state_dbg !== 2'd3) begin
            bad++;
            $display("FAIL bad_stop_break: state=%0d required 3", state_dbg);
        end
        tick(1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1);
        total++;
        if (err_cnt != 1) begin
            bad++;
            $display("FAIL bad_stop_err_count: got %0d required 1", err_cnt);
        end
        total++;
        if (vdat_q.size() != 1 || vdat_q[0] !== 8'h0F) begin
            bad++;
            $display("FAIL bad_stop_next_word: count=%0d first=%h required 1/0f",
                     vdat_q.size(), (vdat_q.size() > 0) ? vdat_q[0] : 8'h00);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w;
        w = 8'hB6;
        send_frame(8'h77, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(w[k], 1'b0);
        bus.d_in = w[4];
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.frame_err !== 1'b0 ||
            bus.overrun !== 1'b0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: valid=%b data=%h err=%b ovr=%b state=%0d required all 0",
                     bus.out_valid, bus.out_data, bus.frame_err, bus.overrun, state_dbg);
        end
        #1;
        rst = 1'b0;
        tick(1'b1, 1'b1);
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h81) begin
            bad++;
            $display("FAIL after_reset_word: valid=%b data=%h required 1/81", bus.out_valid, bus.out_data);
        end
        tick(1'b1, 1'b1);
    endtask

    // Random frames with random idle gaps and occasional bad stop bits, consumer always ready:
    // every good frame must appear once, in order; every bad frame gives one frame_err.
    task automatic test_random();
        logic [W-1:0] w;
        logic         bad_stop;
        logic         prev_bad;
        int           gap;
        int           exp_err;
        clear_logs();
        exp_q.delete();
        exp_err  = 0;
        prev_bad = 1'b0;
        for (int f = 0; f < 40; f++) begin
            w        = W'($urandom);
            bad_stop = ($urandom_range(0, 5) == 0);
            gap      = $urandom_range(0, 3);
            if (prev_bad && gap == 0) gap = 1;
            repeat (gap) tick(1'b1, 1'b1);
            send_frame(w, !bad_stop, 1'b1, 1'b1);
            if (bad_stop) exp_err++;
            else exp_q.push_back(w);
            prev_bad = bad_stop;
        end
        repeat (2) tick(1'b1, 1'b1);
        total++;
        if (err_cnt != exp_err) begin
            bad++;
            $display("FAIL rand_err_count: got %0d required %0d", err_cnt, exp_err);
        end
        total++;
        if (vdat_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_word_count: got %0d required %0d", vdat_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < vdat_q.size(); i++) begin
            total++;
            if (vdat_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_word[%0d]: got %h required %h", i, vdat_q[i], exp_q[i]);
            end
        end
        total++;
        if (bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL rand_overrun: got %b required 0", bus.overrun);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        err_cnt       = 0;
        rst           = 1'b1;
        bus.d_in      = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset();
        test_accept_and_load();
        test_bad_stop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
